reg_grp_ctrl: RTL

- Parametrised successor to the CPU-to-register-bus bridge in the OpenFlow switch datapath.
- Buffers CPU register write/read requests toward the register interface, and buffers read responses back to the CPU.
- Adds the following to the fixed-width bridge:
  - configurable widths and FIFO depths
  - read-response timeout with error word
  - occupancy/overflow status
  - explicit busy handshake

---
 rtl/reg_grp_ctrl.sv | 292 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/reg_grp_ctrl.sv
// reg_grp_ctrl: CPU-to-register-bus bridge with a request FIFO, a read-response FIFO,
// a read timeout that returns an error word, and a status word with sticky overflow flags.
// Optional build macro REG_GRP_CTRL_STATS_EN adds 16-bit drop/timeout counters that are
// read through status accesses with the bus addr field set to 1, 2 or 3.
module reg_grp_ctrl #(
  parameter int unsigned ADDR_WIDTH    = 23,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned WR_DEPTH_BITS = 4,
  parameter int unsigned RD_DEPTH_BITS = 4,
  parameter int unsigned RD_TIMEOUT    = 255,
  parameter logic [31:0] ERR_WORD      = 32'hDEAD_DEAD
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [ADDR_WIDTH+DATA_WIDTH:0]   switch_reg_wr_data_bus,
  input  logic [1:0]                       switch_reg_ctrl,
  input  logic                             switch_reg_vld,
  output logic                             switch_reg_busy,
  output logic [DATA_WIDTH-1:0]            switch_reg_rd_data_bus,
  output logic                             switch_reg_ack,
  output logic                             reg_fifo_empty,
  input  logic                             reg_fifo_rd_en,
  output logic                             reg_rd_wr_L,
  output logic [ADDR_WIDTH-1:0]            reg_addr,
  output logic [DATA_WIDTH-1:0]            reg_wr_data,
  input  logic [DATA_WIDTH-1:0]            reg_rd_data,
  input  logic                             reg_rd_vld
);

  localparam int unsigned ReqWidth = 1 + ADDR_WIDTH + DATA_WIDTH;
  localparam int unsigned WrDepth  = 32'd1 << WR_DEPTH_BITS;
  localparam int unsigned RdDepth  = 32'd1 << RD_DEPTH_BITS;

  typedef enum logic [1:0] {StIdle, StRdWait, StSend} state_e;

  function automatic logic [7:0] sat8(input logic [31:0] v);
    return (v > 32'd255) ? 8'hFF : v[7:0];
  endfunction

  // ---------------------------------------------------------------- request FIFO
  logic [ReqWidth-1:0]      wr_mem [WrDepth];
  logic [WR_DEPTH_BITS-1:0] wr_rd_ptr_q, wr_wr_ptr_q;
  logic [WR_DEPTH_BITS:0]   wr_cnt_q;
  logic [ReqWidth-1:0]      wr_head;
  logic wr_empty, wr_full, wr_nearly_full, wr_push_req, wr_push, wr_pop, wr_drop;
  logic busy_q;

  assign wr_empty       = (wr_cnt_q == '0);
  assign wr_full        = (wr_cnt_q == (WR_DEPTH_BITS+1)'(WrDepth));
  assign wr_nearly_full = (32'(wr_cnt_q) >= (WrDepth - 1));
  assign wr_head        = wr_mem[wr_rd_ptr_q];
  assign wr_push_req    = switch_reg_vld & ~switch_reg_ctrl[1] & ~busy_q;
  assign wr_pop         = reg_fifo_rd_en & ~wr_empty;
  // A pop on the same edge frees the slot, so a push into a full FIFO still lands.
  assign wr_push        = wr_push_req & (~wr_full | wr_pop);
  assign wr_drop        = wr_push_req & wr_full & ~wr_pop;

  // Request FIFO storage; no reset needed, the head is gated while empty.
  always_ff @(posedge clk) begin
    if (wr_push) wr_mem[wr_wr_ptr_q] <= switch_reg_wr_data_bus;
  end

  // Request FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_rd_ptr_q <= '0;
      wr_wr_ptr_q <= '0;
      wr_cnt_q    <= '0;
    end else begin
      if (wr_push) wr_wr_ptr_q <= wr_wr_ptr_q + WR_DEPTH_BITS'(1);
      if (wr_pop)  wr_rd_ptr_q <= wr_rd_ptr_q + WR_DEPTH_BITS'(1);
      if (wr_push && !wr_pop)      wr_cnt_q <= wr_cnt_q + (WR_DEPTH_BITS+1)'(1);
      else if (!wr_push && wr_pop) wr_cnt_q <= wr_cnt_q - (WR_DEPTH_BITS+1)'(1);
    end
  end

  assign reg_fifo_empty = wr_empty;
  assign reg_rd_wr_L    = ~wr_empty & wr_head[ReqWidth-1];
  assign reg_addr       = wr_empty ? '0 : wr_head[DATA_WIDTH +: ADDR_WIDTH];
  assign reg_wr_data    = wr_empty ? '0 : wr_head[DATA_WIDTH-1:0];

  // ---------------------------------------------------------------- read-response FIFO
  logic [DATA_WIDTH-1:0]    rd_mem [RdDepth];
  logic [RD_DEPTH_BITS-1:0] rd_rd_ptr_q, rd_wr_ptr_q;
  logic [RD_DEPTH_BITS:0]   rd_cnt_q;
  logic [DATA_WIDTH-1:0]    rd_head;
  logic rd_empty, rd_full, rd_nearly_full, rd_push, rd_pop, rd_drop;

  assign rd_empty       = (rd_cnt_q == '0);
  assign rd_full        = (rd_cnt_q == (RD_DEPTH_BITS+1)'(RdDepth));
  assign rd_nearly_full = (32'(rd_cnt_q) >= (RdDepth - 1));
  assign rd_head        = rd_mem[rd_rd_ptr_q];
  assign rd_push        = reg_rd_vld & (~rd_full | rd_pop);
  assign rd_drop        = reg_rd_vld & rd_full & ~rd_pop;

  // Read-response storage.
  always_ff @(posedge clk) begin
    if (rd_push) rd_mem[rd_wr_ptr_q] <= reg_rd_data;
  end

  // Read-response pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_rd_ptr_q <= '0;
      rd_wr_ptr_q <= '0;
      rd_cnt_q    <= '0;
    end else begin
      if (rd_push) rd_wr_ptr_q <= rd_wr_ptr_q + RD_DEPTH_BITS'(1);
      if (rd_pop)  rd_rd_ptr_q <= rd_rd_ptr_q + RD_DEPTH_BITS'(1);
      if (rd_push && !rd_pop)      rd_cnt_q <= rd_cnt_q + (RD_DEPTH_BITS+1)'(1);
      else if (!rd_push && rd_pop) rd_cnt_q <= rd_cnt_q - (RD_DEPTH_BITS+1)'(1);
    end
  end

  // ---------------------------------------------------------------- outstanding reads
  logic [7:0] out_cnt_q;
  logic       out_inc;

  assign out_inc = wr_pop & wr_head[ReqWidth-1];

  // Saturating count of read requests handed to the register side minus responses seen.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_cnt_q <= '0;
    end else if (out_inc && !reg_rd_vld && out_cnt_q != 8'hFF) begin
      out_cnt_q <= out_cnt_q + 8'd1;
    end else if (!out_inc && reg_rd_vld && out_cnt_q != 8'h00) begin
      out_cnt_q <= out_cnt_q - 8'd1;
    end
  end

  // ---------------------------------------------------------------- status
  logic [31:0]           status_word;
  logic [DATA_WIDTH-1:0] status_sel;
  logic                  stat_rd, stat_clr;
  logic                  wr_ovf_q, rd_ovf_q;

  // Status word assembly from current occupancy and flags.
  always_comb begin
    status_word        = '0;
    status_word[0]     = wr_empty;
    status_word[1]     = wr_full;
    status_word[2]     = wr_nearly_full;
    status_word[3]     = rd_empty;
    status_word[4]     = rd_full;
    status_word[5]     = rd_nearly_full;
    status_word[6]     = wr_ovf_q;
    status_word[7]     = rd_ovf_q;
    status_word[15:8]  = sat8(32'(wr_cnt_q));
    status_word[23:16] = sat8(32'(rd_cnt_q));
    status_word[31:24] = out_cnt_q;
  end

`ifdef REG_GRP_CTRL_STATS_EN
  logic [ADDR_WIDTH-1:0] stat_addr;
  logic [15:0]           wr_drop_cnt_q, rd_drop_cnt_q, to_cnt_q;
  logic                  to_evt;

  function automatic logic [15:0] stat_next(input logic [15:0] cur, input logic clr,
                                            input logic inc);
    if (clr) return {15'd0, inc};
    if (inc && cur != 16'hFFFF) return cur + 16'd1;
    return cur;
  endfunction

  assign stat_addr = switch_reg_wr_data_bus[DATA_WIDTH +: ADDR_WIDTH];
  assign stat_clr  = stat_rd & (stat_addr == '0);
  assign to_evt    = (state_q == StRdWait) & rd_empty & (timer_q == 16'd1);

  // Counter or status-word select by the addr field of the status access.
  always_comb begin
    status_sel = '0;
    if (stat_addr == '0)                    status_sel = DATA_WIDTH'(status_word);
    else if (stat_addr == ADDR_WIDTH'(1))   status_sel = DATA_WIDTH'(wr_drop_cnt_q);
    else if (stat_addr == ADDR_WIDTH'(2))   status_sel = DATA_WIDTH'(rd_drop_cnt_q);
    else if (stat_addr == ADDR_WIDTH'(3))   status_sel = DATA_WIDTH'(to_cnt_q);
  end

  // Drop/timeout counters; an event on the reading edge survives the clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_drop_cnt_q <= '0;
      rd_drop_cnt_q <= '0;
      to_cnt_q      <= '0;
    end else begin
      wr_drop_cnt_q <= stat_next(wr_drop_cnt_q, stat_rd & (stat_addr == ADDR_WIDTH'(1)), wr_drop);
      rd_drop_cnt_q <= stat_next(rd_drop_cnt_q, stat_rd & (stat_addr == ADDR_WIDTH'(2)), rd_drop);
      to_cnt_q      <= stat_next(to_cnt_q, stat_rd & (stat_addr == ADDR_WIDTH'(3)), to_evt);
    end
  end
`else
  assign stat_clr   = stat_rd;
  assign status_sel = DATA_WIDTH'(status_word);
`endif

  // Sticky overflow flags; a drop on the status-read edge wins over the clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ovf_q <= 1'b0;
      rd_ovf_q <= 1'b0;
    end else begin
      wr_ovf_q <= (wr_ovf_q & ~stat_clr) | wr_drop;
      rd_ovf_q <= (rd_ovf_q & ~stat_clr) | rd_drop;
    end
  end

  // ---------------------------------------------------------------- CPU-side FSM
  state_e                state_q, state_d;
  logic [15:0]           timer_q, timer_d;
  logic [DATA_WIDTH-1:0] send_q, send_d, rd_data_q, rd_data_d;
  logic                  busy_d, ack_q, ack_d;

  // FSM, timer, response and handshake registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      timer_q   <= '0;
      send_q    <= '0;
      rd_data_q <= '0;
      busy_q    <= 1'b0;
      ack_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      send_q    <= send_d;
      rd_data_q <= rd_data_d;
      busy_q    <= busy_d;
      ack_q     <= ack_d;
    end
  end

  // Next state: busy stays high through the ack cycle and drops the cycle after.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    send_d    = send_q;
    rd_data_d = rd_data_q;
    busy_d    = busy_q;
    ack_d     = 1'b0;
    rd_pop    = 1'b0;
    stat_rd   = 1'b0;
    unique case (state_q)
      StIdle: begin
        busy_d = 1'b0;
        // busy_q still high here means the ack cycle of the previous read.
        if (switch_reg_vld && !busy_q) begin
          if (switch_reg_ctrl[1]) begin
            ack_d     = 1'b1;
            rd_data_d = status_sel;
            stat_rd   = 1'b1;
          end else if (switch_reg_ctrl[0]) begin
            busy_d = 1'b1;
            if (!rd_empty) begin
              rd_pop  = 1'b1;
              send_d  = rd_head;
              state_d = StSend;
            end else begin
              timer_d = 16'(RD_TIMEOUT);
              state_d = StRdWait;
            end
          end
        end
      end
      StRdWait: begin
        busy_d = 1'b1;
        if (!rd_empty) begin
          rd_pop  = 1'b1;
          send_d  = rd_head;
          state_d = StSend;
        end else if (timer_q == 16'd1) begin
          ack_d     = 1'b1;
          rd_data_d = DATA_WIDTH'(ERR_WORD);
          state_d   = StIdle;
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      StSend: begin
        busy_d    = 1'b1;
        ack_d     = 1'b1;
        rd_data_d = send_q;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign switch_reg_busy        = busy_q;
  assign switch_reg_ack         = ack_q;
  assign switch_reg_rd_data_bus = rd_data_q;

endmodule
